// File: rtl/div11_radix4_seq_if.sv
// Operand/result handshake bundle for the divide-by-11 sequencer.
// master = operand source + result consumer, slave = the divider.
interface div11_radix4_seq_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_dividend;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_quotient;
    logic [3:0]       out_remainder;
    logic             busy;

    modport master (
        output in_valid, in_dividend, out_ready,
        input  in_ready, out_valid, out_quotient, out_remainder, busy
    );

    modport slave (
        input  in_valid, in_dividend, out_ready,
        output in_ready, out_valid, out_quotient, out_remainder, busy
    );
endinterface

// File: rtl/div11_radix4_seq.sv
// Sequential divide-by-11: one radix-4 quotient digit per cycle, MSB first.
// IDLE accepts a dividend, STEP runs WIDTH/2 digit steps, DONE holds the result.
module div11_radix4_seq #(
    parameter  int WIDTH = 64,
    localparam int STEPS = WIDTH / 2
) (
    input  logic                clk,
    input  logic                rst_n,
    div11_radix4_seq_if.slave   bus
);
    localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

    typedef struct packed {
        logic [1:0] q;
        logic [3:0] rem;
    } step_t;

    // rem <= 10 keeps t <= 43, so compare-subtract against 33/22/11 covers every case.
    function automatic step_t rem_step(input logic [3:0] r, input logic [1:0] d);
        logic [5:0] t;
        step_t      s;
        t = {r, d};
        if (t >= 6'd33) begin
            s.q   = 2'd3;
            s.rem = 4'(t - 6'd33);
        end else if (t >= 6'd22) begin
            s.q   = 2'd2;
            s.rem = 4'(t - 6'd22);
        end else if (t >= 6'd11) begin
            s.q   = 2'd1;
            s.rem = 4'(t - 6'd11);
        end else begin
            s.q   = 2'd0;
            s.rem = t[3:0];
        end
        return s;
    endfunction

    state_t           state;
    logic [WIDTH-1:0] div;
    logic [WIDTH-1:0] quot;
    logic [3:0]       rem;
    logic [CW-1:0]    cnt;
    step_t            st;

    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;
    logic [WIDTH-1:0] out_quotient_r;
    logic [3:0]       out_remainder_r;

    assign st = rem_step(rem, div[WIDTH-1:WIDTH-2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            div             <= '0;
            quot            <= '0;
            rem             <= '0;
            cnt             <= '0;
            in_ready_r      <= 1'b1;
            out_valid_r     <= 1'b0;
            busy_r          <= 1'b0;
            out_quotient_r  <= '0;
            out_remainder_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        div        <= bus.in_dividend;
                        rem        <= '0;
                        quot       <= '0;
                        cnt        <= CW'(STEPS - 1);
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state      <= STEP;
                    end
                end
                STEP: begin
                    quot <= {quot[WIDTH-3:0], st.q};
                    rem  <= st.rem;
                    div  <= {div[WIDTH-3:0], 2'b00};
                    if (cnt == '0) begin
                        // Result registers load only here, so they never expose a partial quotient.
                        out_quotient_r  <= {quot[WIDTH-3:0], st.q};
                        out_remainder_r <= st.rem;
                        out_valid_r     <= 1'b1;
                        busy_r          <= 1'b0;
                        state           <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready      = in_ready_r;
    assign bus.out_valid     = out_valid_r;
    assign bus.busy          = busy_r;
    assign bus.out_quotient  = out_quotient_r;
    assign bus.out_remainder = out_remainder_r;
endmodule

// File: tb/tb_div11_radix4_seq.sv
// Self-checking bench for div11_radix4_seq against plain x/11, x%11 arithmetic.
module tb_div11_radix4_seq;
    localparam int W     = 64;
    localparam int STEPS = W / 2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    div11_radix4_seq_if #(.WIDTH(W)) ifc ();
    div11_radix4_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

    // Running remainder must stay a valid mod-11 residue on every step cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ifc.busy === 1'b1) begin
            n_total++;
            if (dut.rem > 4'd10) $display("FAIL rem_range: rem=%0d required<=10", dut.rem);
            else n_pass++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [W-1:0] d, output bit ok);
        int k = 0;
        while (ifc.in_ready !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        ok = (ifc.in_ready === 1'b1);
        ifc.in_valid    = 1'b1;
        ifc.in_dividend = d;
        tick();
        ifc.in_valid    = 1'b0;
        ifc.in_dividend = {$urandom, $urandom};
    endtask

    task automatic wait_out(output int lat, output int busy_n, output bit rdy_seen);
        lat = 0; busy_n = 0; rdy_seen = 0;
        while (ifc.out_valid !== 1'b1 && lat < 200) begin
            if (ifc.busy === 1'b1) busy_n++;
            if (ifc.in_ready !== 1'b0) rdy_seen = 1;
            tick();
            lat++;
        end
    endtask

    task automatic handshake();
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifc.in_valid = 1'b0; ifc.out_ready = 1'b0; ifc.in_dividend = '0;
        #12;
        n_total++;
        if ({ifc.in_ready, ifc.out_valid, ifc.busy} !== 3'b100)
            $display("FAIL reset_ctrl: rdy/vld/busy=%b required 100", {ifc.in_ready, ifc.out_valid, ifc.busy});
        else n_pass++;
        n_total++;
        if (ifc.out_quotient !== '0 || ifc.out_remainder !== 4'd0)
            $display("FAIL reset_data: q=%h r=%0d required 0/0", ifc.out_quotient, ifc.out_remainder);
        else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        tick();
        n_total++;
        if ({ifc.in_ready, ifc.out_valid, ifc.busy} !== 3'b100)
            $display("FAIL post_reset_idle: rdy/vld/busy=%b required 100", {ifc.in_ready, ifc.out_valid, ifc.busy});
        else n_pass++;
    endtask

    task automatic test_zero();
        bit ok, rs; int lat, bn;
        accept('0, ok);
        wait_out(lat, bn, rs);
        n_total++;
        if (!ok || lat != STEPS) $display("FAIL zero_latency: ok=%0d lat=%0d required %0d", ok, lat, STEPS);
        else n_pass++;
        n_total++;
        if (bn != STEPS) $display("FAIL zero_busy_cycles: got %0d required %0d", bn, STEPS);
        else n_pass++;
        n_total++;
        if (ifc.out_quotient !== '0 || ifc.out_remainder !== 4'd0 || rs)
            $display("FAIL zero_result: q=%h r=%0d rdy_seen=%0d required 0/0/0", ifc.out_quotient, ifc.out_remainder, rs);
        else n_pass++;
        handshake();
        n_total++;
        if ({ifc.in_ready, ifc.out_valid} !== 2'b10)
            $display("FAIL zero_return_idle: rdy/vld=%b required 10", {ifc.in_ready, ifc.out_valid});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] dv [3] = '{64'd10, 64'd11, 64'd121};
        logic [W-1:0] eq [3] = '{64'd0, 64'd1, 64'd11};
        logic [3:0]   er [3] = '{4'd10, 4'd0, 4'd0};
        bit ok, rs; int lat, bn;
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            accept(dv[i], ok);
            wait_out(lat, bn, rs);
            n_total++;
            if (!ok || lat != STEPS || ifc.out_quotient !== eq[i] || ifc.out_remainder !== er[i])
                $display("FAIL b2b_result[%0d]: lat=%0d q=%0d r=%0d required lat=%0d q=%0d r=%0d",
                         i, lat, ifc.out_quotient, ifc.out_remainder, STEPS, eq[i], er[i]);
            else n_pass++;
            n_total++;
            if (rs || ifc.in_ready !== 1'b0) $display("FAIL b2b_inready_low[%0d]: in_ready rose early", i);
            else n_pass++;
            tick();
            n_total++;
            if ({ifc.in_ready, ifc.out_valid} !== 2'b10 || ifc.out_quotient !== eq[i])
                $display("FAIL b2b_after_hs[%0d]: rdy/vld=%b q=%0d required 10 q=%0d",
                         i, {ifc.in_ready, ifc.out_valid}, ifc.out_quotient, eq[i]);
            else n_pass++;
        end
        ifc.out_ready = 1'b0;
    endtask

    task automatic test_corners();
        logic [W-1:0] dv [2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
        logic [W-1:0] eq [2] = '{64'h1745_D174_5D17_45D1, 64'h0BA2_E8BA_2E8B_A2E8};
        logic [3:0]   er [2] = '{4'd4, 4'd8};
        bit ok, rs; int lat, bn;
        for (int i = 0; i < 2; i++) begin
            accept(dv[i], ok);
            wait_out(lat, bn, rs);
            n_total++;
            if (!ok || lat >= 200 || ifc.out_quotient !== eq[i] || ifc.out_remainder !== er[i])
                $display("FAIL corner[%0d]: q=%h r=%0d required q=%h r=%0d",
                         i, ifc.out_quotient, ifc.out_remainder, eq[i], er[i]);
            else n_pass++;
            handshake();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] d1;
        bit ok, rs; int lat, bn;
        d1 = {$urandom, $urandom};
        accept(d1, ok);
        wait_out(lat, bn, rs);
        for (int i = 0; i < 10; i++) begin
            ifc.in_valid    = (i % 2 == 1);
            ifc.in_dividend = {$urandom, $urandom};
            tick();
            n_total++;
            if ({ifc.out_valid, ifc.in_ready} !== 2'b10 || ifc.out_quotient !== d1 / 64'd11
                || ifc.out_remainder !== 4'(d1 % 64'd11))
                $display("FAIL bp_hold[%0d]: vld/rdy=%b q=%h r=%0d required 10 q=%h r=%0d", i,
                         {ifc.out_valid, ifc.in_ready}, ifc.out_quotient, ifc.out_remainder,
                         d1 / 64'd11, 4'(d1 % 64'd11));
            else n_pass++;
        end
        ifc.in_valid = 1'b0;
        handshake();
        n_total++;
        if ({ifc.in_ready, ifc.out_valid} !== 2'b10)
            $display("FAIL bp_release: rdy/vld=%b required 10", {ifc.in_ready, ifc.out_valid});
        else n_pass++;
        accept(64'd1000, ok);
        wait_out(lat, bn, rs);
        n_total++;
        if (!ok || lat != STEPS || ifc.out_quotient !== 64'd90 || ifc.out_remainder !== 4'd10)
            $display("FAIL bp_fresh_op: lat=%0d q=%0d r=%0d required lat=%0d q=90 r=10",
                     lat, ifc.out_quotient, ifc.out_remainder, STEPS);
        else n_pass++;
        handshake();
    endtask

    task automatic test_reset_midop();
        logic [W-1:0] d = 64'h1234_5678_9ABC_DEF0;
        bit ok, rs; int lat, bn, seen;
        accept(d, ok);
        repeat (15) tick();
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({ifc.in_ready, ifc.out_valid, ifc.busy} !== 3'b100 || ifc.out_remainder !== 4'd0)
            $display("FAIL midop_reset_ctrl: rdy/vld/busy=%b r=%0d required 100 r=0",
                     {ifc.in_ready, ifc.out_valid, ifc.busy}, ifc.out_remainder);
        else n_pass++;
        n_total++;
        if (ifc.out_quotient !== '0) $display("FAIL midop_reset_q: q=%h required 0", ifc.out_quotient);
        else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        ifc.out_ready = 1'b1;
        seen = 0;
        repeat (40) begin
            tick();
            if (ifc.out_valid !== 1'b0) seen++;
        end
        ifc.out_ready = 1'b0;
        n_total++;
        if (seen != 0) $display("FAIL midop_no_valid: out_valid seen %0d cycles required 0", seen);
        else n_pass++;
        accept(d, ok);
        wait_out(lat, bn, rs);
        n_total++;
        if (!ok || lat != STEPS || ifc.out_quotient !== d / 64'd11 || ifc.out_remainder !== 4'(d % 64'd11))
            $display("FAIL midop_rerun: q=%h r=%0d required q=%h r=%0d",
                     ifc.out_quotient, ifc.out_remainder, d / 64'd11, 4'(d % 64'd11));
        else n_pass++;
        handshake();
    endtask

    task automatic test_random();
        logic [W-1:0] d;
        bit ok, rs; int lat, bn, fails;
        fails = 0;
        for (int n = 0; n < 1200; n++) begin
            repeat ($urandom_range(0, 3)) tick();
            case ($urandom_range(0, 7))
                0:       d = 64'($urandom_range(0, 50));
                1:       d = ~64'($urandom_range(0, 50));
                default: d = {$urandom, $urandom};
            endcase
            accept(d, ok);
            lat = 0;
            while (ifc.out_valid !== 1'b1 && lat < 200) begin
                ifc.in_valid    = $urandom_range(0, 1) == 1;
                ifc.in_dividend = {$urandom, $urandom};
                tick();
                lat++;
            end
            ifc.in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
            n_total++;
            if (!ok || lat >= 200 || ifc.out_quotient !== d / 64'd11 || ifc.out_remainder !== 4'(d % 64'd11)) begin
                fails++;
                if (fails <= 10)
                    $display("FAIL random[%0d]: d=%h q=%h r=%0d required q=%h r=%0d", n, d,
                             ifc.out_quotient, ifc.out_remainder, d / 64'd11, 4'(d % 64'd11));
            end else n_pass++;
            handshake();
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_back_to_back();
        test_corners();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
